// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares the single write port of a synchronous FIFO among num_req producers.
// One producer at a time is granted the port for a burst of at most max_burst
// accepted beats. Its beats go straight onto fifo_wr_en / fifo_wr_data in the
// same cycle as the handshake. Priority rotates round-robin starting after the
// most recently released producer, so no producer can starve.
//
// Handshake semantics (valid/ready):
//   A beat from producer i transfers in a cycle where req_valid[i] and
//   req_ready[i] are both high at the rising clock edge. A producer must hold
//   req_valid[i] and its data slice stable while req_ready[i] is low. Dropping
//   req_valid[i] while granted ends the grant. Back-pressure comes only from
//   fifo_full: fifo_wr_en is never high while fifo_full is high.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   req_valid      in   [num_req]             producer i has a word
//   req_data       in   [num_req*data_width]  producer i data at [i*data_width +: data_width]
//   req_ready      out  [num_req]             one-hot or zero; granted producer may transfer
//   fifo_full      in   FIFO full flag
//   fifo_wr_en     out  FIFO write enable
//   fifo_wr_data   out  [data_width]          FIFO write data
//   grant_valid    out  high while a producer owns the port
//   grant_id       out  [id_width]            granted producer; meaningful with grant_valid
//   dbg_state_o    out  FSM state (0 = IDLE, 1 = GRANT)
//   dbg_beat_cnt_o out  [4]                   beats accepted in the current grant
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int data_width = 8,
  parameter int num_req    = 4,
  parameter int id_width   = 2,
  parameter int max_burst  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [num_req-1:0]             req_valid,
  input  logic [num_req*data_width-1:0]  req_data,
  output logic [num_req-1:0]             req_ready,
  input  logic                           fifo_full,
  output logic                           fifo_wr_en,
  output logic [data_width-1:0]          fifo_wr_data,
  output logic                           grant_valid,
  output logic [id_width-1:0]            grant_id,
  output logic                           dbg_state_o,
  output logic [3:0]                     dbg_beat_cnt_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Counter value of the final beat of a full burst.
  localparam logic [3:0]          LAST_BEAT   = 4'(max_burst - 1);
  // Reset value of last_id: makes producer 0 the first in priority order.
  localparam logic [id_width-1:0] LAST_ID_RST = id_width'(num_req - 1);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_e              state_q,    state_d;
  logic [id_width-1:0] grant_id_q, grant_id_d;
  logic [id_width-1:0] last_id_q,  last_id_d;
  logic [3:0]          beat_cnt_q, beat_cnt_d;

  // ---------------------------------------------------------------------------
  // Round-robin winner search: candidates last_id+1, last_id+2, ... wrapping
  // modulo num_req. num_req is a power of two equal to 2**id_width, so plain
  // id_width-bit addition gives the wrap for free.
  // ---------------------------------------------------------------------------
  logic                win_found;
  logic [id_width-1:0] win_id;
  logic [id_width-1:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= num_req; k++) begin
      cand = last_id_q + id_width'(k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Selected producer's request and data
  // ---------------------------------------------------------------------------
  logic                  sel_valid;
  logic [data_width-1:0] sel_data;
  logic                  xfer;

  always_comb begin
    sel_valid = req_valid[grant_id_q];
    sel_data  = req_data[int'(grant_id_q)*data_width +: data_width];
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_id_d    = last_id_q;
    beat_cnt_d   = beat_cnt_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    grant_valid  = 1'b0;
    xfer         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // No handshake is possible here; this is the one-cycle bubble
        // between grants where arbitration happens.
        if (win_found) begin
          state_d    = ST_GRANT;
          grant_id_d = win_id;
          beat_cnt_d = '0;
        end
      end

      ST_GRANT: begin
        grant_valid             = 1'b1;
        req_ready[grant_id_q]   = !fifo_full;
        fifo_wr_data            = sel_data;
        xfer                    = sel_valid && !fifo_full;
        fifo_wr_en              = xfer;

        // Exit checks in priority order: burst complete, then producer gone.
        // A full FIFO with the producer still valid is a stall: the grant
        // and the beat count both hold.
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (beat_cnt_q == LAST_BEAT) begin
            last_id_d = grant_id_q;
            state_d   = ST_IDLE;
          end
        end else if (!sel_valid) begin
          last_id_d = grant_id_q;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register. Reset forces IDLE immediately, which in turn forces every
  // combinational output to zero without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_id_q <= '0;
      last_id_q  <= LAST_ID_RST;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_id       = grant_id_q;
  assign dbg_state_o    = state_q;
  assign dbg_beat_cnt_o = beat_cnt_q;

endmodule
